// File: rtl/mfp_bot_update_sync_pkg.sv
// Shared constants for the Rojobot-to-AHB status crossing.
// Default widths and synchronizer depth used by mfp_bot_update_sync and its tests.
package mfp_bot_update_sync_pkg;
    localparam int MFP_N_BOTINFO       = 32;
    localparam int MFP_SYNC_STAGES_DEF = 2;
    localparam int MFP_OVR_W_DEF       = 8;
    localparam int MFP_UPD_W_DEF       = 16;
endpackage

// File: rtl/mfp_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Carries one toggle level from a foreign clock domain into i_clk.
module mfp_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/mfp_bot_update_sync.sv
// Moves Rojobot status words from bot_clk into HCLK with a toggle req/ack handshake
// and maintains the sticky update flag, overrun and update counters for the GPIO block.
module mfp_bot_update_sync
    import mfp_bot_update_sync_pkg::*;
#(
    parameter int SYNC_STAGES = MFP_SYNC_STAGES_DEF,
    parameter int OVR_W       = MFP_OVR_W_DEF,
    parameter int UPD_W       = MFP_UPD_W_DEF
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     bot_clk,
    input  logic                     bot_upd_pulse,
    input  logic [MFP_N_BOTINFO-1:0] bot_info_in,
    input  logic                     IO_INT_ACK,
    output logic [MFP_N_BOTINFO-1:0] IO_BotInfo,
    output logic                     IO_BotUpdt_Sync,
    output logic [OVR_W-1:0]         ovr_count,
    output logic [UPD_W-1:0]         upd_count,
    output logic                     bot_busy
);

    localparam logic [UPD_W-1:0] UPD_ONE = {{(UPD_W-1){1'b0}}, 1'b1};
    localparam logic [OVR_W-1:0] OVR_ONE = {{(OVR_W-1){1'b0}}, 1'b1};

    // Handshake: the bot side flips r_req_tgl when r_hold holds a new word; the HCLK side
    // copies r_hold and echoes the toggle on r_ack_tgl. A transfer is in flight while the
    // two toggles differ, and r_hold is frozen for that whole window.
    logic                     r_req_tgl;
    logic [MFP_N_BOTINFO-1:0] r_hold;
    logic                     w_ack_sync;
    logic                     w_bot_busy;

    logic                     w_req_sync;
    logic                     r_req_prev;
    logic                     r_ack_tgl;
    logic                     w_new_upd;
    logic                     r_ack_q;
    logic                     w_ack_rise;
    logic [MFP_N_BOTINFO-1:0] r_bot_info;
    logic                     r_flag;
    logic [OVR_W-1:0]         r_ovr;
    logic [UPD_W-1:0]         r_upd;

    // ---------------- bot_clk domain ----------------
    mfp_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .i_clk   (bot_clk),
        .i_rst_n (HRESETn),
        .i_d     (r_ack_tgl),
        .o_q     (w_ack_sync)
    );

    assign w_bot_busy = r_req_tgl ^ w_ack_sync;

    always_ff @(posedge bot_clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_req_tgl <= 1'b0;
            r_hold    <= '0;
        end else if (bot_upd_pulse && !w_bot_busy) begin
            r_hold    <= bot_info_in;
            r_req_tgl <= ~r_req_tgl;
        end
    end

    // ---------------- HCLK domain ----------------
    mfp_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_d     (r_req_tgl),
        .o_q     (w_req_sync)
    );

    assign w_new_upd  = w_req_sync ^ r_req_prev;
    assign w_ack_rise = IO_INT_ACK & ~r_ack_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_req_prev <= 1'b0;
            r_ack_tgl  <= 1'b0;
            r_ack_q    <= 1'b0;
            r_bot_info <= '0;
            r_upd      <= '0;
        end else begin
            r_req_prev <= w_req_sync;
            r_ack_q    <= IO_INT_ACK;
            if (w_new_upd) begin
                // r_hold is stable here because the bot side cannot reload until the ack returns.
                r_bot_info <= r_hold;
                r_ack_tgl  <= w_req_sync;
                r_upd      <= r_upd + UPD_ONE;
            end
        end
    end

    // Set wins over a simultaneous acknowledge so an arriving word is never hidden.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_flag <= 1'b0;
            r_ovr  <= '0;
        end else begin
            if (w_new_upd) begin
                r_flag <= 1'b1;
            end else if (w_ack_rise) begin
                r_flag <= 1'b0;
            end
            if (w_new_upd && r_flag && !w_ack_rise && (r_ovr != '1)) begin
                r_ovr <= r_ovr + OVR_ONE;
            end
        end
    end

    assign IO_BotInfo      = r_bot_info;
    assign IO_BotUpdt_Sync = r_flag;
    assign ovr_count       = r_ovr;
    assign upd_count       = r_upd;
    assign bot_busy        = w_bot_busy;

endmodule

// File: tb/tb_mfp_bot_update_sync.sv
// Self-checking bench for mfp_bot_update_sync: directed transfers, acks, overruns,
// dropped pulses and reset; a monitor pops expected words as each update lands.
module tb_mfp_bot_update_sync;

  logic        HCLK = 1'b0;
  logic        bot_clk = 1'b0;
  logic        HRESETn = 1'b0;
  logic        bot_upd_pulse = 1'b0;
  logic [31:0] bot_info_in = '0;
  logic        IO_INT_ACK = 1'b0;
  logic [31:0] IO_BotInfo;
  logic        IO_BotUpdt_Sync;
  logic [7:0]  ovr_count;
  logic [15:0] upd_count;
  logic        bot_busy;

  mfp_bot_update_sync dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .bot_clk         (bot_clk),
    .bot_upd_pulse   (bot_upd_pulse),
    .bot_info_in     (bot_info_in),
    .IO_INT_ACK      (IO_INT_ACK),
    .IO_BotInfo      (IO_BotInfo),
    .IO_BotUpdt_Sync (IO_BotUpdt_Sync),
    .ovr_count       (ovr_count),
    .upd_count       (upd_count),
    .bot_busy        (bot_busy)
  );

  // ---------------- clock / reset ----------------
  always #10 HCLK = ~HCLK;      // 50 MHz
  always #7  bot_clk = ~bot_clk; // ~71 MHz, unrelated phase

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [55:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] m_upd = '0;
  logic [7:0]  m_ovr = '0;
  bit          m_flag = 1'b0;
  logic [15:0] last_upd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [55:0] pack(input logic [31:0] info, input logic [15:0] upd,
                                       input logic [7:0] ovr);
    return {info, upd, ovr};
  endfunction

  task automatic model_push(input logic [31:0] v, input bit coincident_ack);
    if (m_flag && !coincident_ack && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
    m_upd  = m_upd + 16'd1;
    m_flag = 1'b1;
    exp_q.push_back(pack(v, m_upd, m_ovr));
  endtask

  // Monitor: a change of upd_count marks a delivered update.
  always @(negedge HCLK) begin
    logic [55:0] e;
    if (!HRESETn) begin
      last_upd = '0;
    end else if (upd_count != last_upd) begin
      last_upd = upd_count;
      if (exp_q.size() == 0) begin
        chk("unexpected_update", {16'd0, upd_count}, {16'd0, m_upd});
      end else begin
        e = exp_q.pop_front();
        chk("mon_info", IO_BotInfo, e[55:24]);
        chk("mon_upd", {16'd0, upd_count}, {16'd0, e[23:8]});
        chk("mon_ovr", {24'd0, ovr_count}, {24'd0, e[7:0]});
        chk("mon_flag", {31'd0, IO_BotUpdt_Sync}, 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    HRESETn = 1'b0;
    bot_upd_pulse = 1'b0;
    IO_INT_ACK = 1'b0;
    repeat (3) @(negedge HCLK);
    exp_q.delete();
    m_upd = '0; m_ovr = '0; m_flag = 1'b0;
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic drive_pulse(input logic [31:0] v);
    @(negedge bot_clk);
    bot_info_in = v;
    bot_upd_pulse = 1'b1;
    @(negedge bot_clk);
    bot_upd_pulse = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    model_push(v, 1'b0);
    drive_pulse(v);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bot_busy && n < 100) begin
      @(negedge bot_clk);
      n++;
    end
    if (bot_busy) chk({name, "_busy_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge HCLK);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_info"}, IO_BotInfo, 32'd0);
    chk({name, "_flag"}, {31'd0, IO_BotUpdt_Sync}, 32'd0);
    chk({name, "_ovr"}, {24'd0, ovr_count}, 32'd0);
    chk({name, "_upd"}, {16'd0, upd_count}, 32'd0);
    chk({name, "_busy"}, {31'd0, bot_busy}, 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int seen;
    int n;
    bit hit;

    // Reset and idle
    apply_reset();
    check_all_zero("reset");
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge HCLK);
      if (IO_BotUpdt_Sync || upd_count != 0) seen++;
    end
    chk("idle_no_flag", seen, 0);

    // Single transfer with latency measurement
    model_push(32'hA5C3_0F12, 1'b0);
    @(negedge bot_clk);
    bot_info_in = 32'hA5C3_0F12;
    bot_upd_pulse = 1'b1;
    @(posedge bot_clk);
    #1;
    chk("busy_after_pulse", {31'd0, bot_busy}, 32'd1);
    fork
      begin
        @(negedge bot_clk);
        bot_upd_pulse = 1'b0;
      end
    join_none
    n = 0;
    while (IO_BotInfo !== 32'hA5C3_0F12 && n < 10) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    chk("latency_in_window", {31'd0, (n >= 2 && n <= 4)}, 32'd1);
    wait_idle("single");
    chk("busy_falls", {31'd0, bot_busy}, 32'd0);
    chk("single_upd", {16'd0, upd_count}, 32'd1);

    // Acknowledge held high: only the rising edge clears
    @(negedge HCLK);
    IO_INT_ACK = 1'b1;
    m_flag = 1'b0;
    @(negedge HCLK);
    chk("ack_clear_first_edge", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    repeat (9) @(negedge HCLK);
    send(32'h0000_0055);
    wait_idle("ack_high");
    chk("flag_set_ack_high", {31'd0, IO_BotUpdt_Sync}, 32'd1);
    repeat (5) @(negedge HCLK);
    chk("flag_held_ack_high", {31'd0, IO_BotUpdt_Sync}, 32'd1);
    IO_INT_ACK = 1'b0;

    // Three unacked updates, then saturate the overrun counter
    apply_reset();
    for (int v = 1; v <= 3; v++) begin
      send(v);
      wait_idle("ovr3");
    end
    chk("ovr3_info", IO_BotInfo, 32'd3);
    chk("ovr3_ovr", {24'd0, ovr_count}, 32'd2);
    chk("ovr3_upd", {16'd0, upd_count}, 32'd3);
    for (int i = 0; i < 300; i++) begin
      send(32'h1000_0000 + i);
      wait_idle("sat");
    end
    chk("ovr_saturated", {24'd0, ovr_count}, 32'h0000_00FF);
    chk("sat_upd", {16'd0, upd_count}, 32'd303);

    // Back-to-back pulses: only the first is accepted
    apply_reset();
    model_push(32'd10, 1'b0);
    @(negedge bot_clk);
    bot_info_in = 32'd10;
    bot_upd_pulse = 1'b1;
    @(negedge bot_clk);
    chk("busy_during_drop", {31'd0, bot_busy}, 32'd1);
    bot_info_in = 32'd11;
    @(negedge bot_clk);
    bot_info_in = 32'd12;
    @(negedge bot_clk);
    bot_upd_pulse = 1'b0;
    wait_idle("drop");
    chk("drop_info", IO_BotInfo, 32'd10);
    chk("drop_upd", {16'd0, upd_count}, 32'd1);

    // Update landing on the same edge as an ack rising edge
    model_push(32'h0000_0077, 1'b1);
    drive_pulse(32'h0000_0077);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge HCLK);
      if (dut.w_new_upd) begin
        IO_INT_ACK = 1'b1;
        hit = 1'b1;
      end
    end
    chk("coincide_seen", {31'd0, hit}, 32'd1);
    @(negedge HCLK);
    chk("coincide_flag", {31'd0, IO_BotUpdt_Sync}, 32'd1);
    chk("coincide_ovr", {24'd0, ovr_count}, 32'd0);
    IO_INT_ACK = 1'b0;
    wait_idle("coincide");

    // Reset in the middle of a transfer
    @(negedge bot_clk);
    bot_info_in = 32'hDEAD_BEEF;
    bot_upd_pulse = 1'b1;
    @(posedge bot_clk);
    fork
      begin
        @(negedge bot_clk);
        bot_upd_pulse = 1'b0;
      end
    join_none
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    exp_q.delete();
    m_upd = '0; m_ovr = '0; m_flag = 1'b0;
    repeat (5) @(negedge HCLK);
    check_all_zero("midrst");
    HRESETn = 1'b1;
    repeat (50) @(negedge HCLK);
    check_all_zero("post_rst");

    repeat (10) @(negedge HCLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
